// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode encodings, receiver FSM states and
// counter sizing helpers used by the UART receive path.
package uart_pkg;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_e;

   // Width of a counter that must hold the values 0..n-1 (at least one bit).
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Mode 2'b11 is reserved and behaves like PAR_NONE.
   function automatic logic parity_on(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Word-delivery side of the configurable UART receiver: valid/ready holding
// register plus per-word and sticky error flags.
interface uart_rx_cfg_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] o_data;
   logic                 o_valid;
   logic                 o_parity_err;
   logic                 o_frame_err;
   logic                 o_overrun;
   logic                 i_ready;
   logic                 i_clr_err;

   modport master (
      output o_data, o_valid, o_parity_err, o_frame_err, o_overrun,
      input  i_ready, i_clr_err
   );

   modport slave (
      input  o_data, o_valid, o_parity_err, o_frame_err, o_overrun,
      output i_ready, i_clr_err
   );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input; the reset value
// is a parameter so idle-high and idle-low lines can share it.
module uart_rx_sync #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_d,
   output logic o_q
);

   logic [1:0] sync_q;

   // NOTE: sequential state always uses non-blocking assignments so every
   // flop samples pre-edge values and the two stages really form a chain.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         sync_q <= {2{RESET_VAL}};
      end else begin
         sync_q <= {sync_q[0], i_d};
      end
   end

   assign o_q = sync_q[1];

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised oversampling UART receiver with runtime parity/stop selection,
// start-glitch rejection, error flags and a valid/ready output register.
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_bd_tick,
   input  logic          i_rx,
   input  logic [1:0]    i_parity_mode,
   input  logic          i_two_stop,
   uart_rx_cfg_if.master rx_if
);

   localparam int TICK_W = cnt_width(OVERSAMPLE);
   localparam int BIT_W  = cnt_width(DATA_BITS);
   localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

   logic rxs;

   uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_d     (i_rx),
      .o_q     (rxs)
   );

   // Frame reception state
   rx_state_e            state_q, state_d;
   logic [TICK_W-1:0]    tick_q, tick_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic                 stop2_q, stop2_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 acc_q, acc_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic [1:0]           mode_q, mode_d;
   logic                 two_q, two_d;
   logic                 done_q, done_d;

   // Delivery register state
   logic [DATA_BITS-1:0] data_q;
   logic                 valid_q;
   logic                 perr_out_q;
   logic                 ferr_out_q;
   logic                 overrun_q;

   logic mid_bit;
   assign mid_bit = i_bd_tick && (tick_q == TICK_LAST);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         stop2_q <= 1'b0;
         shreg_q <= '0;
         acc_q   <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         mode_q  <= PAR_NONE;
         two_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         stop2_q <= stop2_d;
         shreg_q <= shreg_d;
         acc_q   <= acc_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         mode_q  <= mode_d;
         two_q   <= two_d;
         done_q  <= done_d;
      end
   end

   // NOTE: every always_comb output gets its hold value first, so no path
   // through the case statement can leave a signal unassigned (no latches).
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      stop2_d = stop2_q;
      shreg_d = shreg_q;
      acc_d   = acc_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      mode_d  = mode_q;
      two_d   = two_q;
      done_d  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (!rxs) begin
               state_d = ST_START;
               tick_d  = '0;
               mode_d  = i_parity_mode;
               two_d   = i_two_stop;
            end
         end

         // Half-bit check of the start bit rejects short glitches.
         ST_START: begin
            if (i_bd_tick) begin
               if (tick_q == TICK_HALF) begin
                  if (rxs) begin
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_DATA;
                     tick_d  = '0;
                     bit_d   = '0;
                     stop2_d = 1'b0;
                     acc_d   = 1'b0;
                     perr_d  = 1'b0;
                     ferr_d  = 1'b0;
                  end
               end else begin
                  tick_d = tick_q + TICK_W'(1);
               end
            end
         end

         ST_DATA: begin
            if (mid_bit) begin
               tick_d  = '0;
               shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
               acc_d   = acc_q ^ rxs;
               if (bit_q == BIT_LAST) begin
                  state_d = parity_on(mode_q) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end else if (i_bd_tick) begin
               tick_d = tick_q + TICK_W'(1);
            end
         end

         ST_PARITY: begin
            if (mid_bit) begin
               tick_d  = '0;
               perr_d  = (mode_q == PAR_ODD) ? !(acc_q ^ rxs) : (acc_q ^ rxs);
               state_d = ST_STOP;
            end else if (i_bd_tick) begin
               tick_d = tick_q + TICK_W'(1);
            end
         end

         // Leave at the stop-bit centre so a back-to-back start edge is seen.
         ST_STOP: begin
            if (mid_bit) begin
               tick_d = '0;
               ferr_d = ferr_q | !rxs;
               if (two_q && !stop2_q) begin
                  stop2_d = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end else if (i_bd_tick) begin
               tick_d = tick_q + TICK_W'(1);
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   logic deliver;
   logic drop;
   assign deliver = done_q && (!valid_q || rx_if.i_ready);
   assign drop    = done_q && valid_q && !rx_if.i_ready;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         data_q     <= '0;
         valid_q    <= 1'b0;
         perr_out_q <= 1'b0;
         ferr_out_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         if (deliver) begin
            data_q     <= shreg_q;
            perr_out_q <= perr_q;
            ferr_out_q <= ferr_q;
            valid_q    <= 1'b1;
         end else if (valid_q && rx_if.i_ready) begin
            valid_q <= 1'b0;
         end

         // A new overrun beats a simultaneous clear.
         if (drop) begin
            overrun_q <= 1'b1;
         end else if (rx_if.i_clr_err) begin
            overrun_q <= 1'b0;
         end
      end
   end

   assign rx_if.o_data       = data_q;
   assign rx_if.o_valid      = valid_q;
   assign rx_if.o_parity_err = perr_out_q;
   assign rx_if.o_frame_err  = ferr_out_q;
   assign rx_if.o_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: directed frame table, multi-cycle
// corner sequences, and randomized frames checked against a frame-level model.
module tb_uart_rx_cfg;

   localparam int OS = 16;

   logic       i_clk;
   logic       i_reset;
   logic       i_bd_tick;
   logic       i_rx;
   logic [1:0] i_parity_mode;
   logic       i_two_stop;

   uart_rx_cfg_if #(.DATA_BITS(8)) rx_if ();

   uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_bd_tick     (i_bd_tick),
      .i_rx          (i_rx),
      .i_parity_mode (i_parity_mode),
      .i_two_stop    (i_two_stop),
      .rx_if         (rx_if)
   );

   typedef struct packed {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
   } word_t;

   typedef struct {
      logic [7:0] data;
      logic [1:0] mode;
      logic       two;
      logic       pbit;
      logic       s1;
      logic       s2;
      logic [7:0] exp_data;
      logic       exp_perr;
      logic       exp_ferr;
   } vec_t;

   int    n_cmp = 0;
   int    n_err = 0;
   word_t got_q[$];
   word_t exp_q[$];
   int    valid_run = 0;
   int    valid_run_max = 0;
   int    tick_div = 0;

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Baud tick: one clock wide, every third clock, changed on the falling edge.
   initial begin
      i_bd_tick = 1'b0;
      forever begin
         @(negedge i_clk);
         tick_div  = (tick_div == 2) ? 0 : tick_div + 1;
         i_bd_tick = (tick_div == 0);
      end
   end

   // Transfer monitor: records every consumed word and the length of valid runs.
   always @(negedge i_clk) begin
      if (!i_reset) begin
         if (rx_if.o_valid && rx_if.i_ready)
            got_q.push_back({rx_if.o_data, rx_if.o_parity_err, rx_if.o_frame_err});
         if (rx_if.o_valid) valid_run = valid_run + 1;
         else valid_run = 0;
         if (valid_run > valid_run_max) valid_run_max = valid_run;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) begin
         do @(posedge i_clk); while (!i_bd_tick);
      end
      #1;
   endtask

   task automatic send_bit(input logic b);
      i_rx = b;
      wait_ticks(OS);
   endtask

   task automatic send_frame(input logic [7:0] data, input logic [1:0] mode, input logic two,
                             input logic pbit, input logic s1, input logic s2,
                             input int gap, input logic scramble);
      i_parity_mode = mode;
      i_two_stop    = two;
      send_bit(1'b0);
      if (scramble) begin
         i_parity_mode = 2'($urandom);
         i_two_stop    = 1'($urandom);
      end
      for (int b = 0; b < 8; b++) send_bit(data[b]);
      if (mode == 2'b01 || mode == 2'b10) send_bit(pbit);
      send_bit(s1);
      if (two) send_bit(s2);
      i_rx = 1'b1;
      wait_ticks(gap);
   endtask

   // Frame-level reference: word contents and flags straight from the line bits.
   function automatic word_t model(input logic [7:0] data, input logic [1:0] mode,
                                   input logic two, input logic pbit,
                                   input logic s1, input logic s2);
      word_t w;
      int ones = 0;
      for (int b = 0; b < 8; b++) ones += int'(data[b]);
      ones += int'(pbit);
      w.data = data;
      if (mode == 2'b01)      w.perr = (ones % 2) != 0;
      else if (mode == 2'b10) w.perr = (ones % 2) == 0;
      else                    w.perr = 1'b0;
      w.ferr = !s1 || (two && !s2);
      return w;
   endfunction

   vec_t vecs[10];

   initial begin
      word_t w;
      word_t e;
      int    nr;

      vecs[0] = '{8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
      vecs[1] = '{8'h03, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
      vecs[2] = '{8'h03, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0};
      vecs[3] = '{8'h03, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0};
      vecs[4] = '{8'h55, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1};
      vecs[5] = '{8'h96, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h96, 1'b0, 1'b1};
      vecs[6] = '{8'hC3, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0};
      vecs[7] = '{8'h00, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
      vecs[8] = '{8'hFF, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
      vecs[9] = '{8'h81, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 8'h81, 1'b0, 1'b1};

      i_reset         = 1'b1;
      i_rx            = 1'b1;
      i_parity_mode   = 2'b00;
      i_two_stop      = 1'b0;
      rx_if.i_ready   = 1'b1;
      rx_if.i_clr_err = 1'b0;
      repeat (5) @(posedge i_clk);
      #1 i_reset = 1'b0;
      @(negedge i_clk);
      check("reset_outputs",
            {rx_if.o_data, rx_if.o_valid, rx_if.o_parity_err, rx_if.o_frame_err, rx_if.o_overrun}, 0);
      wait_ticks(OS);

      // Directed frame table
      foreach (vecs[i]) begin
         got_q.delete();
         valid_run_max = 0;
         send_frame(vecs[i].data, vecs[i].mode, vecs[i].two, vecs[i].pbit,
                    vecs[i].s1, vecs[i].s2, 2 * OS, 1'b0);
         check($sformatf("vec%0d_words", i), got_q.size(), 1);
         if (got_q.size() > 0) begin
            w = got_q.pop_front();
            check($sformatf("vec%0d_word", i), 32'(w),
                  32'({vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr}));
         end
         check($sformatf("vec%0d_valid_cycles", i), valid_run_max, 1);
         check($sformatf("vec%0d_overrun", i), rx_if.o_overrun, 0);
      end

      // Overrun: second word dropped while the first is held
      got_q.delete();
      rx_if.i_ready = 1'b0;
      send_frame(8'h11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, OS, 1'b0);
      send_frame(8'h22, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, OS, 1'b0);
      @(negedge i_clk);
      check("ovr_held_valid", rx_if.o_valid, 1);
      check("ovr_held_data", rx_if.o_data, 8'h11);
      check("ovr_flag_set", rx_if.o_overrun, 1);
      @(posedge i_clk);
      #1 rx_if.i_ready = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      check("ovr_consumed_words", got_q.size(), 1);
      if (got_q.size() > 0) begin
         w = got_q.pop_front();
         check("ovr_consumed_data", w.data, 8'h11);
      end
      check("ovr_valid_drop", rx_if.o_valid, 0);
      check("ovr_sticky", rx_if.o_overrun, 1);
      @(posedge i_clk);
      #1 rx_if.i_clr_err = 1'b1;
      @(posedge i_clk);
      #1 rx_if.i_clr_err = 1'b0;
      @(negedge i_clk);
      check("ovr_cleared", rx_if.o_overrun, 0);

      // Start-bit glitch, then a clean frame
      got_q.delete();
      i_rx = 1'b0;
      wait_ticks(4);
      i_rx = 1'b1;
      wait_ticks(2 * OS);
      check("glitch_no_word", got_q.size(), 0);
      check("glitch_no_valid", rx_if.o_valid, 0);
      send_frame(8'h3C, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 2 * OS, 1'b0);
      check("post_glitch_words", got_q.size(), 1);
      if (got_q.size() > 0) begin
         w = got_q.pop_front();
         check("post_glitch_word", 32'(w), 32'({8'h3C, 1'b0, 1'b0}));
      end

      // Reset in the middle of the data bits of 0xF0
      got_q.delete();
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b0);
      @(posedge i_clk);
      #1 i_reset = 1'b1;
      i_rx = 1'b1;
      repeat (3) @(negedge i_clk);
      check("mid_reset_outputs",
            {rx_if.o_data, rx_if.o_valid, rx_if.o_parity_err, rx_if.o_frame_err, rx_if.o_overrun}, 0);
      @(posedge i_clk);
      #1 i_reset = 1'b0;
      wait_ticks(2 * OS);
      check("mid_reset_no_word", got_q.size(), 0);
      send_frame(8'h0F, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 2 * OS, 1'b0);
      check("post_reset_words", got_q.size(), 1);
      if (got_q.size() > 0) begin
         w = got_q.pop_front();
         check("post_reset_word", 32'(w), 32'({8'h0F, 1'b0, 1'b0}));
      end

      // Randomized frames against the reference model
      got_q.delete();
      exp_q.delete();
      for (int k = 0; k < 40; k++) begin
         logic [7:0] d;
         logic [1:0] m;
         logic       two, pb, s1, s2, last_stop;
         int         gap;
         d   = 8'($urandom);
         m   = 2'($urandom);
         two = 1'($urandom);
         pb  = 1'($urandom);
         s1  = ($urandom_range(0, 4) != 0);
         s2  = ($urandom_range(0, 4) != 0);
         last_stop = two ? s2 : s1;
         gap = last_stop ? $urandom_range(0, 20) : OS + $urandom_range(0, 8);
         exp_q.push_back(model(d, m, two, pb, s1, s2));
         send_frame(d, m, two, pb, s1, s2, gap, 1'b1);
      end
      wait_ticks(3 * OS);
      check("rand_word_count", got_q.size(), exp_q.size());
      nr = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int k = 0; k < nr; k++) begin
         check($sformatf("rand%0d_word", k), 32'(got_q[k]), 32'(exp_q[k]));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
